// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - writeback trap/mret sequencer with mtvec/mepc/mcause CSRs
module trap_ctrl #(
  parameter logic [31:0] RESET_MTVEC  = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        trap0_i,
  input  logic        misaligned_i,
  input  logic        trap1_i,
  input  logic [31:0] pc_0_i,
  input  logic [31:0] pc_1_i,
  input  logic        mret_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        csr_we_i,
  output logic [31:0] csr_rdata_o,
  output logic        kill1_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o
);

  localparam logic [11:0] ADDR_MTVEC  = 12'h305;
  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
  localparam logic [3:0]  FLUSH_INIT  = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtvec;
  logic        r_ret_mret;

  logic        w_idle;
  logic        w_take_trap;
  logic        w_take_mret;
  logic [31:0] w_trap_pc;
  logic [31:0] w_trap_cause;
  logic        w_wr_mtvec;
  logic        w_wr_mepc;
  logic        w_wr_mcause;

  // Trap events are only accepted in IDLE; slot 0 has priority and a trap beats an mret.
  assign w_idle       = (r_state == S_IDLE);
  assign w_take_trap  = w_idle & (trap0_i | trap1_i);
  assign w_take_mret  = w_idle & ~(trap0_i | trap1_i) & mret_i;
  assign w_trap_pc    = trap0_i ? pc_0_i : pc_1_i;
  assign w_trap_cause = {30'd0, ~(trap0_i & misaligned_i), 1'b0};
  assign w_wr_mtvec   = csr_we_i & (csr_addr_i == ADDR_MTVEC);
  assign w_wr_mepc    = csr_we_i & (csr_addr_i == ADDR_MEPC);
  assign w_wr_mcause  = csr_we_i & (csr_addr_i == ADDR_MCAUSE);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: trap flushes first, mret redirects immediately, redirect lasts one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_take_trap) begin
          w_next_state = S_FLUSH;
        end else if (w_take_mret) begin
          w_next_state = S_REDIRECT;
        end
      end
      S_FLUSH: begin
        if (r_cnt <= 4'd1) begin
          w_next_state = S_REDIRECT;
        end
      end
      S_REDIRECT: w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state; kill1 is the only one that follows trap0 combinationally.
  always_comb begin
    flush_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = 32'd0;
    busy_o        = 1'b0;
    kill1_o       = rst_ni & trap0_i & w_idle;
    case (r_state)
      S_FLUSH: begin
        flush_o = 1'b1;
        busy_o  = 1'b1;
      end
      S_REDIRECT: begin
        flush_o       = 1'b1;
        busy_o        = 1'b1;
        redirect_o    = 1'b1;
        redirect_pc_o = r_ret_mret ? r_mepc : {r_mtvec[31:2], 2'b00};
      end
      default: ;
    endcase
  end

  // Flush down-counter, loaded when a trap is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= 4'd0;
    end else if (w_take_trap) begin
      r_cnt <= FLUSH_INIT;
    end else if (r_state == S_FLUSH) begin
      r_cnt <= r_cnt - 4'd1;
    end else begin
      r_cnt <= 4'd0;
    end
  end

  // Remembers whether the pending redirect returns to mepc or enters the trap vector.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ret_mret <= 1'b0;
    end else if (w_take_trap) begin
      r_ret_mret <= 1'b0;
    end else if (w_take_mret) begin
      r_ret_mret <= 1'b1;
    end
  end

  // mtvec: software-writable in any state, word aligned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mtvec <= RESET_MTVEC;
    end else if (w_wr_mtvec) begin
      r_mtvec <= {csr_wdata_i[31:2], 2'b00};
    end
  end

  // mepc/mcause: trap capture overrides a same-cycle software write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mepc   <= 32'd0;
      r_mcause <= 32'd0;
    end else if (w_take_trap) begin
      r_mepc   <= w_trap_pc;
      r_mcause <= w_trap_cause;
    end else begin
      if (w_wr_mepc) begin
        r_mepc <= {csr_wdata_i[31:2], 2'b00};
      end
      if (w_wr_mcause) begin
        r_mcause <= csr_wdata_i;
      end
    end
  end

  // Combinational CSR read mux; unmapped addresses read zero.
  always_comb begin
    csr_rdata_o = 32'd0;
    case (csr_addr_i)
      ADDR_MTVEC:  csr_rdata_o = r_mtvec;
      ADDR_MEPC:   csr_rdata_o = r_mepc;
      ADDR_MCAUSE: csr_rdata_o = r_mcause;
      default:     csr_rdata_o = 32'd0;
    endcase
  end

endmodule
